dmem_arbiter: RTL and testbench

//  Shares the single-port, synchronous-read DATA_MEMORY between the processor

---
 rtl/dmem_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between CPU load/store and an external port; writes complete in the grant cycle, reads return one cycle later.
// CPU has priority and is stalled while its read is pending or ext owns the port; a saturating starvation counter forces an ext grant.
module dmem_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_MemRead,
  input  logic              cpu_MemWrite,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    EXT_RD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   starve_q, starve_d;

  logic cpu_req;
  logic in_idle;
  logic ext_win;
  logic cpu_win;
  logic cpu_wr_gnt;
  logic cpu_rd_gnt;
  logic unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[31:ADDR_W];

  assign cpu_req    = cpu_MemRead | cpu_MemWrite;
  // Reset gates every grant so the reset cycle itself is quiet.
  assign in_idle    = (state_q == IDLE) && !rst;
  assign ext_win    = in_idle && ext_req &&
                      (!cpu_req || (starve_q == CNT_W'(STARVE_LIMIT)));
  assign cpu_win    = in_idle && cpu_req && !ext_win;
  assign cpu_wr_gnt = cpu_win && cpu_MemWrite;
  assign cpu_rd_gnt = cpu_win && !cpu_MemWrite;

  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = cpu_addr[ADDR_W-1:0];
    mem_din    = cpu_wdata;
    ext_gnt    = ext_win;
    ext_rvalid = !rst && (state_q == EXT_RD);
    ext_rdata  = mem_dout;
    cpu_rdata  = mem_dout;
    cpu_stall  = !rst && cpu_req && !cpu_wr_gnt && (state_q != CPU_RD);
    if (ext_win) begin
      mem_we   = ext_we;
      mem_addr = ext_addr;
      mem_din  = ext_wdata;
    end else if (cpu_wr_gnt) begin
      mem_we   = 1'b1;
    end
  end

  always_comb begin
    state_d  = IDLE;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (ext_win && !ext_we) state_d = EXT_RD;
        else if (cpu_rd_gnt)    state_d = CPU_RD;
        else                    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ext_win) begin
      starve_d = '0;
    end else if (ext_req && (starve_q != CNT_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected control/data into queues,
// a negedge monitor pops and compares whenever the DUT presents a result.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_MemRead = 1'b0, cpu_MemWrite = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_stall;
  logic        ext_req = 1'b0, ext_we = 1'b0;
  logic [8:0]  ext_addr = '0;
  logic [31:0] ext_wdata = '0, ext_rdata;
  logic        ext_gnt, ext_rvalid, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;

  dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_MemRead(cpu_MemRead), .cpu_MemWrite(cpu_MemWrite),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory standing in for DATA_MEMORY.
  logic [31:0] mem [512];
  initial for (int i = 0; i < 512; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  string       ctl_nm [$];
  logic [3:0]  ctl_q  [$];
  logic [40:0] wr_q   [$];
  logic [31:0] ext_q  [$];
  logic [31:0] cpu_q  [$];
  bit          done = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: all comparisons happen here, mid-cycle.
  bit prev_cpu_grant = 1'b0;
  always @(negedge clk) begin
    string nm;
    if (ctl_q.size() != 0) begin
      nm = ctl_nm.pop_front();
      chk({nm, " ctl{stall,gnt,rvalid,we}"},
          64'({cpu_stall, ext_gnt, ext_rvalid, mem_we}), 64'(ctl_q.pop_front()));
    end
    if (mem_we) begin
      if (wr_q.size() == 0) chk("unexpected_write", 64'({mem_addr, mem_din}), 64'hDEAD_0000_0000);
      else chk("mem_write{addr,din}", 64'({mem_addr, mem_din}), 64'(wr_q.pop_front()));
    end
    if (ext_rvalid) begin
      if (ext_q.size() == 0) chk("unexpected_ext_rvalid", 64'(ext_rdata), 64'hDEAD_0000_0000);
      else chk("ext_rdata", 64'(ext_rdata), 64'(ext_q.pop_front()));
    end
    if (prev_cpu_grant && !rst) begin
      if (cpu_q.size() == 0) chk("unexpected_cpu_read", 64'(cpu_rdata), 64'hDEAD_0000_0000);
      else chk("cpu_rdata", 64'(cpu_rdata), 64'(cpu_q.pop_front()));
    end
    prev_cpu_grant = !rst && cpu_MemRead && !cpu_MemWrite && cpu_stall && !ext_gnt && !ext_rvalid;
    if (done) begin
      chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
      chk("ext_q_drained", 64'(ext_q.size()), 64'd0);
      chk("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  // One clock cycle of stimulus with its expected {stall,gnt,rvalid,we}.
  task automatic cyc(input string nm, input bit r, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] wd,
                     input bit er, input bit ew, input logic [8:0] ea,
                     input logic [31:0] ewd, input logic [3:0] exp);
    rst = r; cpu_MemRead = rd; cpu_MemWrite = wr; cpu_addr = a; cpu_wdata = wd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ewd;
    ctl_nm.push_back(nm);
    ctl_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset: requests present but everything quiet.
    cyc("rst0", 1, 0, 1, 32'h10, 32'h1, 1, 1, 9'h20, 32'h2, 4'b0000);
    cyc("rst1", 1, 1, 0, 32'h10, 32'h1, 1, 1, 9'h20, 32'h2, 4'b0000);
    cyc("idle", 0, 0, 0, 32'h0, 32'h0, 0, 0, 9'h0, 32'h0, 4'b0000);

    // 1: CPU store then reload.
    wr_q.push_back({9'h010, 32'hDEADBEEF});
    cyc("t1_store", 0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 9'h0, 32'h0, 4'b0001);
    cpu_q.push_back(32'hDEADBEEF);
    cyc("t1_load", 0, 1, 0, 32'h10, 32'h0, 0, 0, 9'h0, 32'h0, 4'b1000);
    cyc("t1_cpurd", 0, 1, 0, 32'h10, 32'h0, 0, 0, 9'h0, 32'h0, 4'b0000);
    cyc("t1_idle", 0, 0, 0, 32'h0, 32'h0, 0, 0, 9'h0, 32'h0, 4'b0000);

    // 2: external write then read.
    wr_q.push_back({9'h020, 32'h12345678});
    cyc("t2_ewr", 0, 0, 0, 32'h0, 32'h0, 1, 1, 9'h20, 32'h12345678, 4'b0101);
    ext_q.push_back(32'h12345678);
    cyc("t2_erd", 0, 0, 0, 32'h0, 32'h0, 1, 0, 9'h20, 32'h0, 4'b0100);
    cyc("t2_extrd", 0, 0, 0, 32'h0, 32'h0, 0, 0, 9'h0, 32'h0, 4'b0010);
    cyc("t2_idle", 0, 0, 0, 32'h0, 32'h0, 0, 0, 9'h0, 32'h0, 4'b0000);

    // 3: CPU loads back-to-back while ext waits; forced grant after 4 waiting cycles.
    cpu_q.push_back(32'hDEADBEEF);
    cyc("t3_c1", 0, 1, 0, 32'h10, 32'h0, 1, 0, 9'h20, 32'h0, 4'b1000);
    cyc("t3_c2", 0, 1, 0, 32'h10, 32'h0, 1, 0, 9'h20, 32'h0, 4'b0000);
    cpu_q.push_back(32'h12345678);
    cyc("t3_c3", 0, 1, 0, 32'h20, 32'h0, 1, 0, 9'h20, 32'h0, 4'b1000);
    cyc("t3_c4", 0, 1, 0, 32'h20, 32'h0, 1, 0, 9'h20, 32'h0, 4'b0000);
    ext_q.push_back(32'h12345678);
    cyc("t3_forced", 0, 1, 0, 32'h10, 32'h0, 1, 0, 9'h20, 32'h0, 4'b1100);
    cyc("t3_extrd", 0, 1, 0, 32'h10, 32'h0, 0, 0, 9'h0, 32'h0, 4'b1010);
    cpu_q.push_back(32'hDEADBEEF);
    cyc("t3_c7", 0, 1, 0, 32'h10, 32'h0, 0, 0, 9'h0, 32'h0, 4'b1000);
    cyc("t3_c8", 0, 1, 0, 32'h10, 32'h0, 0, 0, 9'h0, 32'h0, 4'b0000);
    // Counter cleared: CPU wins again against a fresh ext request.
    cpu_q.push_back(32'hDEADBEEF);
    cyc("t3_cnt0", 0, 1, 0, 32'h10, 32'h0, 1, 0, 9'h20, 32'h0, 4'b1000);
    cyc("t3_c10", 0, 1, 0, 32'h10, 32'h0, 1, 0, 9'h20, 32'h0, 4'b0000);
    ext_q.push_back(32'h12345678);
    cyc("t3_egnt", 0, 0, 0, 32'h0, 32'h0, 1, 0, 9'h20, 32'h0, 4'b0100);
    cyc("t3_extrd2", 0, 0, 0, 32'h0, 32'h0, 0, 0, 9'h0, 32'h0, 4'b0010);

    // 4: read+write together is a write.
    wr_q.push_back({9'h030, 32'hA5A5A5A5});
    cyc("t4_rdwr", 0, 1, 1, 32'h30, 32'hA5A5A5A5, 0, 0, 9'h0, 32'h0, 4'b0001);
    cpu_q.push_back(32'hA5A5A5A5);
    cyc("t4_load", 0, 1, 0, 32'h30, 32'h0, 0, 0, 9'h0, 32'h0, 4'b1000);
    cyc("t4_cpurd", 0, 1, 0, 32'h30, 32'h0, 0, 0, 9'h0, 32'h0, 4'b0000);

    // 5: reset during CPU_RD drops the read; next cycle is a fresh IDLE grant.
    cyc("t5_load", 0, 1, 0, 32'h20, 32'h0, 0, 0, 9'h0, 32'h0, 4'b1000);
    cyc("t5_rst", 1, 1, 0, 32'h20, 32'h0, 0, 0, 9'h0, 32'h0, 4'b0000);
    cpu_q.push_back(32'hDEADBEEF);
    cyc("t5_idle_gnt", 0, 1, 0, 32'h10, 32'h0, 0, 0, 9'h0, 32'h0, 4'b1000);
    cyc("t5_cpurd", 0, 1, 0, 32'h10, 32'h0, 0, 0, 9'h0, 32'h0, 4'b0000);

    // 6: upper address bits ignored; withdrawn ext request never granted.
    wr_q.push_back({9'h004, 32'hCAFEF00D});
    cyc("t6_store", 0, 0, 1, 32'h0000_0204, 32'hCAFEF00D, 0, 0, 9'h0, 32'h0, 4'b0001);
    cpu_q.push_back(32'hCAFEF00D);
    cyc("t6_ld_wd", 0, 1, 0, 32'h4, 32'h0, 1, 1, 9'h40, 32'h00000BAD, 4'b1000);
    cyc("t6_cpurd", 0, 1, 0, 32'h4, 32'h0, 0, 1, 9'h40, 32'h00000BAD, 4'b0000);
    cyc("t6_quiet1", 0, 0, 0, 32'h0, 32'h0, 0, 0, 9'h0, 32'h0, 4'b0000);
    cyc("t6_quiet2", 0, 0, 0, 32'h0, 32'h0, 0, 0, 9'h0, 32'h0, 4'b0000);
    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL timeout: monitor never reached summary");
    $fatal(1);
  end

endmodule
